// File: rtl/and_tree_mc.sv
// Multi-class free-bit allocator: per-class bitmaps with lowest-zero search,
// optional atomic claim, single-bit updates and per-row all-ones summaries.
module and_tree_mc #(
  parameter int NUM_CLASS  = 4,
  parameter int LINE_WIDTH = 64,
  parameter int ROW_WIDTH  = 6,
  parameter int ID_WIDTH   = 8,
  localparam int CW   = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1,
  localparam int COLW = $clog2(LINE_WIDTH),
  localparam int IDXW = ROW_WIDTH + COLW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 srch_valid,
  output logic                 srch_ready,
  input  logic [ID_WIDTH-1:0]  srch_id,
  input  logic [CW-1:0]        srch_class,
  input  logic [ROW_WIDTH-1:0] srch_row,
  input  logic                 srch_mark,
  output logic                 res_valid,
  output logic [ID_WIDTH-1:0]  res_id,
  output logic [CW-1:0]        res_class,
  output logic                 res_found,
  output logic [IDXW-1:0]      res_index,
  input  logic                 upd_valid,
  input  logic [ROW_WIDTH-1:0] upd_row,
  input  logic [COLW-1:0]      upd_col,
  input  logic [NUM_CLASS-1:0] upd_bits,
  output logic                 sum_valid,
  output logic [ROW_WIDTH-1:0] sum_row,
  output logic [NUM_CLASS-1:0] sum_bits,
  output logic                 init_done,
  output logic                 fsm_state
);

  localparam int DEPTH = 1 << ROW_WIDTH;

  // Handshake: a search transfers on a cycle where srch_valid && srch_ready;
  // an update has no ready and transfers whenever upd_valid is high in RUN.
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ROW_WIDTH-1:0] init_row_q;
  logic                 init_we;
  logic                 running;
  logic                 upd_take;
  logic                 srch_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_row_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_row_q <= init_row_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_row_q == ROW_WIDTH'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign running    = (state_q == ST_RUN);
  assign fsm_state  = state_q;
  assign init_done  = running;
  assign srch_ready = running & ~upd_valid;
  assign upd_take   = running & upd_valid;
  assign srch_take  = srch_valid & srch_ready;

  // Stage 1: the accepted operation. The row is read and written back in this
  // stage, so the next operation always observes the previous write.
  logic                 s1_valid;
  logic                 s1_upd;
  logic [ID_WIDTH-1:0]  s1_id;
  logic [CW-1:0]        s1_class;
  logic [ROW_WIDTH-1:0] s1_row;
  logic                 s1_mark;
  logic [COLW-1:0]      s1_col;
  logic [NUM_CLASS-1:0] s1_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_upd   <= 1'b0;
      s1_id    <= '0;
      s1_class <= '0;
      s1_row   <= '0;
      s1_mark  <= 1'b0;
      s1_col   <= '0;
      s1_bits  <= '0;
    end else begin
      s1_valid <= upd_take | srch_take;
      s1_upd   <= upd_take;
      s1_id    <= srch_id;
      s1_class <= srch_class;
      s1_row   <= upd_take ? upd_row : srch_row;
      s1_mark  <= srch_mark & ~upd_take;
      s1_col   <= upd_col;
      s1_bits  <= upd_bits;
    end
  end

  logic [LINE_WIDTH-1:0] mem     [NUM_CLASS][DEPTH];
  logic [LINE_WIDTH-1:0] rd_line [NUM_CLASS];
  logic [LINE_WIDTH-1:0] wr_line [NUM_CLASS];
  logic [NUM_CLASS-1:0]  wr_en;
  logic [NUM_CLASS-1:0]  sum_d;
  logic [LINE_WIDTH-1:0] srch_line;
  logic                  hit;
  logic [COLW-1:0]       hit_col;

  always_comb begin
    srch_line = '0;
    hit       = 1'b0;
    hit_col   = '0;
    wr_en     = '0;
    sum_d     = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      rd_line[c] = mem[c][s1_row];
      wr_line[c] = rd_line[c];
    end
    srch_line = rd_line[s1_class];
    // Scan downward so the last assignment wins: the lowest zero bit.
    for (int i = LINE_WIDTH - 1; i >= 0; i--) begin
      if (!srch_line[i]) begin
        hit     = 1'b1;
        hit_col = COLW'(i);
      end
    end
    if (s1_valid) begin
      if (s1_upd) begin
        for (int c = 0; c < NUM_CLASS; c++) begin
          wr_line[c][s1_col] = s1_bits[c];
        end
        wr_en = '1;
      end else if (s1_mark && hit) begin
        wr_line[s1_class][hit_col] = 1'b1;
        wr_en[s1_class]            = 1'b1;
      end
    end
    for (int c = 0; c < NUM_CLASS; c++) begin
      sum_d[c] = &wr_line[c];
    end
  end

  // Bitmap storage carries no reset; the INIT sweep defines its contents.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (init_we) mem[c][init_row_q] <= '0;
      else if (wr_en[c]) mem[c][s1_row] <= wr_line[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_class <= '0;
      res_found <= 1'b0;
      res_index <= '0;
      sum_valid <= 1'b0;
      sum_row   <= '0;
      sum_bits  <= '0;
    end else begin
      res_valid <= s1_valid & ~s1_upd;
      res_id    <= s1_id;
      res_class <= s1_class;
      res_found <= s1_valid & ~s1_upd & hit;
      res_index <= hit ? {s1_row, hit_col} : '0;
      sum_valid <= s1_valid & (s1_upd | (s1_mark & hit));
      sum_row   <= s1_row;
      sum_bits  <= sum_d;
    end
  end

endmodule

// File: tb/tb_and_tree_mc.sv
// Directed bench for and_tree_mc at default parameters (4 classes, 64-bit rows,
// 64 rows): init sweep, search/claim latency, update summaries, hazards, reset.
module tb_and_tree_mc;

  logic        clk;
  logic        rst_n;
  logic        srch_valid;
  logic        srch_ready;
  logic [7:0]  srch_id;
  logic [1:0]  srch_class;
  logic [5:0]  srch_row;
  logic        srch_mark;
  logic        res_valid;
  logic [7:0]  res_id;
  logic [1:0]  res_class;
  logic        res_found;
  logic [11:0] res_index;
  logic        upd_valid;
  logic [5:0]  upd_row;
  logic [5:0]  upd_col;
  logic [3:0]  upd_bits;
  logic        sum_valid;
  logic [5:0]  sum_row;
  logic [3:0]  sum_bits;
  logic        init_done;
  logic        fsm_state;

  int errors = 0;
  int checks = 0;

  and_tree_mc dut (
    .clk(clk), .rst_n(rst_n),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_id(srch_id),
    .srch_class(srch_class), .srch_row(srch_row), .srch_mark(srch_mark),
    .res_valid(res_valid), .res_id(res_id), .res_class(res_class),
    .res_found(res_found), .res_index(res_index),
    .upd_valid(upd_valid), .upd_row(upd_row), .upd_col(upd_col), .upd_bits(upd_bits),
    .sum_valid(sum_valid), .sum_row(sum_row), .sum_bits(sum_bits),
    .init_done(init_done), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    srch_valid = 1'b0;
    srch_mark  = 1'b0;
    upd_valid  = 1'b0;
  endtask

  task automatic drive_srch(input logic [7:0] id, input logic [1:0] cls,
                            input logic [5:0] row, input logic mark);
    srch_valid = 1'b1;
    srch_id    = id;
    srch_class = cls;
    srch_row   = row;
    srch_mark  = mark;
  endtask

  task automatic drive_upd(input logic [5:0] row, input logic [5:0] col,
                           input logic [3:0] bits);
    upd_valid = 1'b1;
    upd_row   = row;
    upd_col   = col;
    upd_bits  = bits;
  endtask

  // Releases reset and counts cycles until init_done; pokes an update and a
  // search mid-sweep that must both be ignored.
  task automatic run_init(input string tag);
    int n;
    int spurious;
    n = 0;
    spurious = 0;
    rst_n = 1'b1;
    while (!init_done && n < 200) begin
      if (n == 10) begin
        drive_upd(6'd0, 6'd0, 4'hF);
        drive_srch(8'hEE, 2'd0, 6'd0, 1'b1);
        #1;
        checks++;
        if (srch_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_ready_in_init got %b exp 0", tag, srch_ready);
        end
      end else begin
        idle;
      end
      if (res_valid || sum_valid) spurious++;
      tick;
      n++;
    end
    idle;
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL %s_init_cycles got %0d exp 64", tag, n);
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL %s_output_in_init got %0d strobes exp 0", tag, spurious);
    end
    checks++;
    if (fsm_state !== 1'b1) begin
      errors++;
      $display("FAIL %s_state_run got %b exp 1", tag, fsm_state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    idle;
    srch_id = '0; srch_class = '0; srch_row = '0;
    upd_row = '0; upd_col = '0; upd_bits = '0;
    repeat (3) tick;
    checks++;
    if ({init_done, srch_ready, res_valid, sum_valid, fsm_state} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000",
               {init_done, srch_ready, res_valid, sum_valid, fsm_state});
    end
    run_init("reset");
  endtask

  task automatic test_basic_search;
    drive_srch(8'h11, 2'd0, 6'd5, 1'b0);
    tick;
    drive_srch(8'h12, 2'd0, 6'd0, 1'b0);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid got %b exp 0", res_valid);
    end
    tick;
    idle;
    checks++;
    if ({res_valid, res_found, res_id, res_class, res_index} !== {2'b11, 8'h11, 2'd0, 12'd320}) begin
      errors++;
      $display("FAIL basic_row5 got v=%b f=%b id=%h c=%0d idx=%0d exp v=1 f=1 id=11 c=0 idx=320",
               res_valid, res_found, res_id, res_class, res_index);
    end
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_summary got %b exp 0", sum_valid);
    end
    tick;
    // Row 0 must be clean: the update poked during INIT was ignored.
    checks++;
    if ({res_valid, res_found, res_id, res_index} !== {2'b11, 8'h12, 12'd0}) begin
      errors++;
      $display("FAIL basic_row0 got v=%b f=%b id=%h idx=%0d exp v=1 f=1 id=12 idx=0",
               res_valid, res_found, res_id, res_index);
    end
    tick;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_strobe_len got %b exp 0", res_valid);
    end
  endtask

  task automatic test_update_bypass;
    drive_upd(6'd5, 6'd0, 4'b0001);
    tick;
    idle;
    drive_srch(8'h21, 2'd0, 6'd5, 1'b0);
    #1;
    checks++;
    if (srch_ready !== 1'b1) begin
      errors++;
      $display("FAIL upd_ready got %b exp 1", srch_ready);
    end
    tick;
    idle;
    checks++;
    if ({sum_valid, sum_row, sum_bits, res_valid} !== {1'b1, 6'd5, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL upd_summary got v=%b row=%0d bits=%b rv=%b exp v=1 row=5 bits=0000 rv=0",
               sum_valid, sum_row, sum_bits, res_valid);
    end
    tick;
    checks++;
    if ({res_valid, res_found, res_index, sum_valid} !== {2'b11, 12'd321, 1'b0}) begin
      errors++;
      $display("FAIL upd_search got v=%b f=%b idx=%0d sv=%b exp v=1 f=1 idx=321 sv=0",
               res_valid, res_found, res_index, sum_valid);
    end
  endtask

  task automatic test_mark;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive_srch(8'(8'h31 + k), 2'd2, 6'd3, 1'b1);
      else idle;
      tick;
      if (k >= 1) begin
        checks++;
        if ({res_valid, res_found, res_id, res_class, res_index} !==
            {2'b11, 8'(8'h31 + k - 1), 2'd2, 12'(192 + k - 1)}) begin
          errors++;
          $display("FAIL mark_result%0d got v=%b f=%b id=%h c=%0d idx=%0d exp idx=%0d",
                   k - 1, res_valid, res_found, res_id, res_class, res_index, 192 + k - 1);
        end
        checks++;
        if ({sum_valid, sum_row, sum_bits} !== {1'b1, 6'd3, 4'b0000}) begin
          errors++;
          $display("FAIL mark_summary%0d got v=%b row=%0d bits=%b exp v=1 row=3 bits=0000",
                   k - 1, sum_valid, sum_row, sum_bits);
        end
      end
    end
    idle;
  endtask

  task automatic test_fill_row;
    for (int i = 0; i < 65; i++) begin
      if (i < 64) drive_upd(6'd7, 6'(i), 4'b0010);
      else idle;
      tick;
      if (i >= 1) begin
        checks++;
        if ({sum_valid, sum_row, sum_bits} !== {1'b1, 6'd7, (i == 64) ? 4'b0010 : 4'b0000}) begin
          errors++;
          $display("FAIL fill_summary%0d got v=%b row=%0d bits=%b exp v=1 row=7 bits=%b",
                   i - 1, sum_valid, sum_row, sum_bits, (i == 64) ? 4'b0010 : 4'b0000);
        end
      end
    end
    drive_srch(8'h41, 2'd1, 6'd7, 1'b1);
    tick;
    drive_srch(8'h42, 2'd0, 6'd7, 1'b0);
    tick;
    idle;
    checks++;
    if ({res_valid, res_found, res_index, sum_valid} !== {2'b10, 12'd0, 1'b0}) begin
      errors++;
      $display("FAIL full_row got v=%b f=%b idx=%0d sv=%b exp v=1 f=0 idx=0 sv=0",
               res_valid, res_found, res_index, sum_valid);
    end
    tick;
    checks++;
    if ({res_valid, res_found, res_id, res_index} !== {2'b11, 8'h42, 12'd448}) begin
      errors++;
      $display("FAIL other_class_row7 got v=%b f=%b id=%h idx=%0d exp v=1 f=1 id=42 idx=448",
               res_valid, res_found, res_id, res_index);
    end
  endtask

  task automatic test_collision;
    drive_upd(6'd10, 6'd0, 4'b0100);
    drive_srch(8'h51, 2'd2, 6'd10, 1'b0);
    #1;
    checks++;
    if (srch_ready !== 1'b0) begin
      errors++;
      $display("FAIL coll_ready got %b exp 0", srch_ready);
    end
    tick;
    upd_valid = 1'b0;
    #1;
    checks++;
    if (srch_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_ready_next got %b exp 1", srch_ready);
    end
    tick;
    idle;
    checks++;
    if ({sum_valid, sum_row, sum_bits, res_valid} !== {1'b1, 6'd10, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL coll_update got v=%b row=%0d bits=%b rv=%b exp v=1 row=10 bits=0000 rv=0",
               sum_valid, sum_row, sum_bits, res_valid);
    end
    tick;
    checks++;
    if ({res_valid, res_found, res_id, res_index} !== {2'b11, 8'h51, 12'd641}) begin
      errors++;
      $display("FAIL coll_search got v=%b f=%b id=%h idx=%0d exp v=1 f=1 id=51 idx=641",
               res_valid, res_found, res_id, res_index);
    end
  endtask

  task automatic test_back_to_back;
    drive_srch(8'h61, 2'd3, 6'd20, 1'b1);
    tick;
    idle;
    drive_upd(6'd20, 6'd1, 4'b1000);
    tick;
    idle;
    drive_srch(8'h62, 2'd3, 6'd20, 1'b0);
    checks++;
    if ({res_valid, res_index, sum_valid, sum_row} !== {1'b1, 12'd1280, 1'b1, 6'd20}) begin
      errors++;
      $display("FAIL b2b_claim got v=%b idx=%0d sv=%b row=%0d exp v=1 idx=1280 sv=1 row=20",
               res_valid, res_index, sum_valid, sum_row);
    end
    tick;
    idle;
    checks++;
    if ({res_valid, sum_valid, sum_bits} !== {2'b01, 4'b0000}) begin
      errors++;
      $display("FAIL b2b_update got rv=%b sv=%b bits=%b exp rv=0 sv=1 bits=0000",
               res_valid, sum_valid, sum_bits);
    end
    tick;
    checks++;
    if ({res_valid, res_found, res_id, res_index, sum_valid} !== {2'b11, 8'h62, 12'd1282, 1'b0}) begin
      errors++;
      $display("FAIL b2b_search got v=%b f=%b id=%h idx=%0d sv=%b exp v=1 f=1 id=62 idx=1282 sv=0",
               res_valid, res_found, res_id, res_index, sum_valid);
    end
  endtask

  task automatic test_reset_inflight;
    int seen;
    seen = 0;
    drive_srch(8'h71, 2'd0, 6'd5, 1'b1);
    tick;
    drive_srch(8'h72, 2'd0, 6'd5, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    idle;
    checks++;
    if ({res_valid, sum_valid, srch_ready, init_done} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async got rv=%b sv=%b rdy=%b done=%b exp all 0",
               res_valid, sum_valid, srch_ready, init_done);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (res_valid || sum_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_discard got %0d strobes exp 0", seen);
    end
    run_init("rerun");
    drive_srch(8'h73, 2'd1, 6'd7, 1'b0);
    tick;
    drive_srch(8'h74, 2'd2, 6'd3, 1'b0);
    tick;
    idle;
    checks++;
    if ({res_valid, res_found, res_id, res_index} !== {2'b11, 8'h73, 12'd448}) begin
      errors++;
      $display("FAIL rst_row7 got v=%b f=%b id=%h idx=%0d exp v=1 f=1 id=73 idx=448",
               res_valid, res_found, res_id, res_index);
    end
    tick;
    checks++;
    if ({res_valid, res_found, res_index} !== {2'b11, 12'd192}) begin
      errors++;
      $display("FAIL rst_row3 got v=%b f=%b idx=%0d exp v=1 f=1 idx=192",
               res_valid, res_found, res_index);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_basic_search;
    test_update_bypass;
    test_mark;
    test_fill_row;
    test_collision;
    test_back_to_back;
    test_reset_inflight;
    repeat (2) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
